// File: rtl/pong_pkg.sv
// Shared definitions for the pong score keeper: FSM encoding, goal geometry defaults,
// digit-select anode patterns and display glyph constants.
package pong_pkg;

    typedef enum logic [1:0] {
        StPlay   = 2'd0,
        StFreeze = 2'd1,
        StServe  = 2'd2,
        StOver   = 2'd3
    } state_e;

    localparam int unsigned GOAL_LX_DEF  = 12;
    localparam int unsigned GOAL_RX_DEF  = 628;
    localparam int unsigned GOAL_TOP_DEF = 200;
    localparam int unsigned GOAL_BOT_DEF = 280;

    localparam logic [7:0] ANODES_P2 = 8'b11111110;
    localparam logic [7:0] ANODES_P1 = 8'b11101111;

    localparam logic [6:0] GLYPH_ZERO  = 7'b1000000;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    // Goal window is exclusive at both ends.
    function automatic logic in_goal_y(input logic [8:0] y, input logic [8:0] top,
                                       input logic [8:0] bot);
        return (y > top) && (y < bot);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// 3-bit value to active-low 7-segment pattern, segment order {g,f,e,d,c,b,a}.
module seg7_decode
    import pong_pkg::*;
(
    input  logic [2:0] value_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = GLYPH_BLANK;
        case (value_i)
            3'd0:    seg_o = GLYPH_ZERO;
            3'd1:    seg_o = 7'b1111001;
            3'd2:    seg_o = 7'b0100100;
            3'd3:    seg_o = 7'b0110000;
            3'd4:    seg_o = 7'b0011001;
            3'd5:    seg_o = 7'b0010010;
            3'd6:    seg_o = 7'b0000010;
            3'd7:    seg_o = 7'b1111000;
            default: seg_o = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/score_keeper.sv
// Pong score keeper: goal detection, freeze/serve sequencing, game-over handling and a
// two-digit multiplexed 7-segment score display.
module score_keeper
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE     = 7,
    parameter int unsigned FREEZE_FRAMES = 60,
    parameter int unsigned SCAN_DIV      = 50000,
    parameter int unsigned GOAL_LX       = GOAL_LX_DEF,
    parameter int unsigned GOAL_RX       = GOAL_RX_DEF,
    parameter int unsigned GOAL_TOP      = GOAL_TOP_DEF,
    parameter int unsigned GOAL_BOT      = GOAL_BOT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [9:0] ball_x,
    input  logic [8:0] ball_y,
    input  logic       start,
    output logic [2:0] p1_score,
    output logic [2:0] p2_score,
    output logic       hold_ball,
    output logic       serve,
    output logic       serve_dir,
    output logic       game_over,
    output logic       winner,
    output logic [7:0] anodes,
    output logic [6:0] cathodes
);

    localparam logic [9:0]  LX       = 10'(GOAL_LX);
    localparam logic [9:0]  RX       = 10'(GOAL_RX);
    localparam logic [8:0]  TOP      = 9'(GOAL_TOP);
    localparam logic [8:0]  BOT      = 9'(GOAL_BOT);
    localparam logic [2:0]  WIN      = 3'(WIN_SCORE);
    localparam logic [7:0]  FRAMES   = 8'(FREEZE_FRAMES);
    localparam logic [15:0] SCAN_MAX = 16'(SCAN_DIV - 1);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [2:0]  p1_q, p2_q;
    logic        dir_q, winner_q, serve_q, hold_q, over_q;
    logic        tick_q;

    logic        frame_ev, goal_left, goal_right;
    logic [2:0]  p1_inc, p2_inc;

    always_comb begin
        frame_ev   = frame_tick & ~tick_q;
        goal_left  = (ball_x <= LX) && in_goal_y(ball_y, TOP, BOT);
        goal_right = (ball_x >= RX) && in_goal_y(ball_y, TOP, BOT);
        p1_inc     = p1_q + 3'd1;
        p2_inc     = p2_q + 3'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StFreeze;
            cnt_q    <= FRAMES;
            p1_q     <= 3'd0;
            p2_q     <= 3'd0;
            dir_q    <= 1'b1;
            winner_q <= 1'b0;
            serve_q  <= 1'b0;
            hold_q   <= 1'b1;
            over_q   <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            tick_q  <= frame_tick;
            serve_q <= 1'b0;
            unique case (state_q)
                StPlay: begin
                    // Left goal wins a tie so a degenerate geometry never scores twice.
                    if (frame_ev && goal_left) begin
                        p2_q   <= p2_inc;
                        hold_q <= 1'b1;
                        if (p2_inc == WIN) begin
                            state_q  <= StOver;
                            winner_q <= 1'b1;
                            over_q   <= 1'b1;
                        end else begin
                            state_q <= StFreeze;
                            cnt_q   <= FRAMES;
                            dir_q   <= 1'b0;
                        end
                    end else if (frame_ev && goal_right) begin
                        p1_q   <= p1_inc;
                        hold_q <= 1'b1;
                        if (p1_inc == WIN) begin
                            state_q  <= StOver;
                            winner_q <= 1'b0;
                            over_q   <= 1'b1;
                        end else begin
                            state_q <= StFreeze;
                            cnt_q   <= FRAMES;
                            dir_q   <= 1'b1;
                        end
                    end
                end
                StFreeze: begin
                    if (frame_ev) begin
                        if (cnt_q <= 8'd1) begin
                            state_q <= StServe;
                            serve_q <= 1'b1;
                            cnt_q   <= 8'd0;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                end
                StServe: begin
                    state_q <= StPlay;
                    hold_q  <= 1'b0;
                end
                StOver: begin
                    if (start) begin
                        p1_q    <= 3'd0;
                        p2_q    <= 3'd0;
                        dir_q   <= ~winner_q;
                        over_q  <= 1'b0;
                        state_q <= StFreeze;
                        cnt_q   <= FRAMES;
                    end
                end
                default: state_q <= StFreeze;
            endcase
        end
    end

    // Display multiplexing
    logic [15:0] scan_q, scan_d;
    logic        sel_q, sel_d;
    logic [6:0]  cath_q;
    logic [6:0]  seg;

    always_comb begin
        scan_d = scan_q + 16'd1;
        sel_d  = sel_q;
        if (scan_q == SCAN_MAX) begin
            scan_d = 16'd0;
            sel_d  = ~sel_q;
        end
    end

    seg7_decode u_seg7_decode (
        .value_i (sel_q ? p1_q : p2_q),
        .seg_o   (seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_q <= 16'd0;
            sel_q  <= 1'b0;
            cath_q <= GLYPH_ZERO;
        end else begin
            scan_q <= scan_d;
            sel_q  <= sel_d;
            cath_q <= seg;
        end
    end

    assign p1_score  = p1_q;
    assign p2_score  = p2_q;
    assign hold_ball = hold_q;
    assign serve     = serve_q;
    assign serve_dir = dir_q;
    assign game_over = over_q;
    assign winner    = winner_q;
    assign anodes    = sel_q ? ANODES_P1 : ANODES_P2;
    assign cathodes  = cath_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed vectors, corner sequences and a
// randomized run against a rule-level reference model.
module tb_score_keeper;

    localparam int FF  = 60;
    localparam int WIN = 7;
    localparam int SD  = 4;

    logic       clk = 1'b0;
    logic       reset, frame_tick, start;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic [2:0] p1_score, p2_score;
    logic       hold_ball, serve, serve_dir, game_over, winner;
    logic [7:0] anodes;
    logic [6:0] cathodes;

    score_keeper #(
        .WIN_SCORE     (WIN),
        .FREEZE_FRAMES (FF),
        .SCAN_DIV      (SD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .start      (start),
        .p1_score   (p1_score),
        .p2_score   (p2_score),
        .hold_ball  (hold_ball),
        .serve      (serve),
        .serve_dir  (serve_dir),
        .game_over  (game_over),
        .winner     (winner),
        .anodes     (anodes),
        .cathodes   (cathodes)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int serve_cnt = 0;
    int cyc = 0;

    always @(negedge clk) if (serve === 1'b1) serve_cnt++;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic frame(input int x, input int y, input int w);
        ball_x     = 10'(x);
        ball_y     = 9'(y);
        frame_tick = 1'b1;
        repeat (w) @(negedge clk);
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Exactly FF idle frames must elapse before a single-cycle serve releases the ball.
    task automatic freeze_out(input string name);
        int s0;
        s0 = serve_cnt;
        repeat (FF - 1) frame(320, 240, 1);
        chk({name, " no early serve"}, 32'(serve_cnt - s0), 0);
        chk({name, " held in freeze"}, 32'(hold_ball), 1);
        frame(320, 240, 1);
        chk({name, " one serve"}, 32'(serve_cnt - s0), 1);
        chk({name, " released"}, 32'(hold_ball), 0);
    endtask

    typedef struct {
        int x;
        int y;
        int dp1;
        int dp2;
    } vec_t;

    vec_t vecs[10];
    int   xs[10] = '{0, 5, 11, 12, 13, 320, 627, 628, 629, 639};
    int   ys[8]  = '{0, 199, 200, 201, 240, 279, 280, 281};

    int p1e, p2e, s0;
    int m_p1, m_p2, m_left, m_serves, rx, ry, k, dig;
    bit m_over, m_win, m_dir, lg, rg;

    initial begin
        vecs[0] = '{5, 240, 0, 1};
        vecs[1] = '{5, 100, 0, 0};
        vecs[2] = '{12, 201, 0, 1};
        vecs[3] = '{12, 200, 0, 0};
        vecs[4] = '{13, 240, 0, 0};
        vecs[5] = '{628, 279, 1, 0};
        vecs[6] = '{628, 280, 0, 0};
        vecs[7] = '{627, 240, 0, 0};
        vecs[8] = '{639, 250, 1, 0};
        vecs[9] = '{320, 240, 0, 0};

        frame_tick = 1'b0;
        start      = 1'b0;
        ball_x     = 10'd320;
        ball_y     = 9'd240;
        reset      = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset p1", 32'(p1_score), 0);
        chk("reset p2", 32'(p2_score), 0);
        chk("reset hold", 32'(hold_ball), 1);
        chk("reset serve", 32'(serve), 0);
        chk("reset dir", 32'(serve_dir), 1);
        chk("reset over", 32'(game_over), 0);
        chk("reset winner", 32'(winner), 0);
        chk("reset anodes", 32'(anodes), 32'hFE);
        chk("reset cathodes", 32'(cathodes), 32'(glyph(0)));
        reset = 1'b0;

        freeze_out("first serve");
        chk("first serve dir", 32'(serve_dir), 1);

        p1e = 0;
        p2e = 0;
        foreach (vecs[i]) begin
            frame(vecs[i].x, vecs[i].y, 1);
            p1e += vecs[i].dp1;
            p2e += vecs[i].dp2;
            chk($sformatf("vec%0d p1", i), 32'(p1_score), 32'(p1e));
            chk($sformatf("vec%0d p2", i), 32'(p2_score), 32'(p2e));
            chk($sformatf("vec%0d hold", i), 32'(hold_ball), 32'(vecs[i].dp1 + vecs[i].dp2));
            if (vecs[i].dp1 + vecs[i].dp2 != 0) begin
                chk($sformatf("vec%0d dir", i), 32'(serve_dir), 32'(vecs[i].dp1));
                freeze_out($sformatf("vec%0d", i));
            end
        end

        frame(630, 240, 4);
        p1e++;
        chk("long tick p1", 32'(p1_score), 32'(p1e));
        freeze_out("long tick");

        for (int i = 0; i < 3; i++) begin
            frame(5, 240, 1);
            p2e++;
            chk("climb p2", 32'(p2_score), 32'(p2e));
            if (i < 2) freeze_out("climb");
        end

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            k = cyc;
            chk("scan anodes", 32'(anodes), ((k / SD) % 2) ? 32'hEF : 32'hFE);
            dig = (((k - 1) / SD) % 2) ? p1e : p2e;
            chk("scan cathodes", 32'(cathodes), 32'(glyph(dig)));
        end
        freeze_out("after scan");

        for (int i = 0; i < 4; i++) begin
            frame(630, 240, 1);
            p1e++;
            if (i < 3) freeze_out("to win");
        end
        chk("win p1", 32'(p1_score), 7);
        chk("win over", 32'(game_over), 1);
        chk("win winner", 32'(winner), 0);
        chk("win hold", 32'(hold_ball), 1);
        frame(630, 240, 1);
        frame(5, 240, 1);
        chk("frozen p1", 32'(p1_score), 7);
        chk("frozen p2", 32'(p2_score), 32'(p2e));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("restart p1", 32'(p1_score), 0);
        chk("restart p2", 32'(p2_score), 0);
        chk("restart over", 32'(game_over), 0);
        chk("restart dir", 32'(serve_dir), 1);
        freeze_out("restart");

        frame(5, 240, 1);
        repeat (FF - 10) frame(320, 240, 1);
        s0 = serve_cnt;
        #2 reset = 1'b1;
        #1;
        chk("midreset p1", 32'(p1_score), 0);
        chk("midreset p2", 32'(p2_score), 0);
        chk("midreset hold", 32'(hold_ball), 1);
        chk("midreset serve", 32'(serve), 0);
        chk("midreset dir", 32'(serve_dir), 1);
        chk("midreset anodes", 32'(anodes), 32'hFE);
        chk("midreset cathodes", 32'(cathodes), 32'(glyph(0)));
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("midreset no serve", 32'(serve_cnt - s0), 0);
        freeze_out("post reset");

        m_p1 = 0; m_p2 = 0; m_left = 0; m_over = 0; m_win = 0; m_dir = 1; m_serves = 0;
        s0 = serve_cnt;
        for (int it = 0; it < 1200; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                @(negedge clk);
                if (m_over) begin
                    m_p1 = 0; m_p2 = 0; m_dir = !m_win; m_over = 0; m_left = FF;
                end
            end else begin
                k  = $urandom_range(0, 10);
                rx = (k == 10) ? $urandom_range(0, 639) : xs[k];
                k  = $urandom_range(0, 8);
                ry = (k == 8) ? $urandom_range(0, 479) : ys[k];
                frame(rx, ry, $urandom_range(1, 4));
                lg = (rx <= 12) && (ry > 200) && (ry < 280);
                rg = (rx >= 628) && (ry > 200) && (ry < 280);
                if (m_over) begin
                end else if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) m_serves++;
                end else if (lg) begin
                    m_p2++;
                    if (m_p2 == WIN) begin m_over = 1; m_win = 1; end
                    else begin m_left = FF; m_dir = 0; end
                end else if (rg) begin
                    m_p1++;
                    if (m_p1 == WIN) begin m_over = 1; m_win = 0; end
                    else begin m_left = FF; m_dir = 1; end
                end
            end
            chk("rand p1", 32'(p1_score), 32'(m_p1));
            chk("rand p2", 32'(p2_score), 32'(m_p2));
            chk("rand hold", 32'(hold_ball), 32'(m_over || m_left > 0));
            chk("rand over", 32'(game_over), 32'(m_over));
            chk("rand dir", 32'(serve_dir), 32'(m_dir));
            chk("rand serves", 32'(serve_cnt - s0), 32'(m_serves));
            if (m_over) chk("rand winner", 32'(winner), 32'(m_win));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
